// File: rtl/bk_multiword_add_seq_if.sv
// Operand/result handshake bundle for bk_multiword_add_seq.
// Optional macro BK_SUB_EN adds the in_sub request line.
interface bk_multiword_add_seq_if #(
  parameter int unsigned NWORDS = 4
);
  localparam int unsigned W = 32 * NWORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
`ifdef BK_SUB_EN
  logic         in_sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;

`ifdef BK_SUB_EN
  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
`endif
endinterface

// File: rtl/bk_multiword_add_seq.sv
// Sequential multi-precision adder: one 32-bit limb per clock through a
// single Brent-Kung core, limb carry rippled through a register.
// Optional macro BK_SUB_EN enables A-B via inverted B and carry-in of 1.

// 32-bit Brent-Kung prefix adder core (purely combinational).
module bk_add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] gg;
  logic [31:0] pp;

  // Up-sweep then down-sweep prefix tree; gg[i] becomes the carry out of bit i.
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = g;
    pp = p;
    // Fold carry-in into bit 0 so every prefix already includes it.
    gg[0] = g[0] | (p[0] & cin);
    for (int unsigned d = 0; d < 5; d++) begin
      for (int unsigned i = (2 << d) - 1; i < 32; i += (2 << d)) begin
        gg[5'(i)] = gg[5'(i)] | (pp[5'(i)] & gg[5'(i - (1 << d))]);
        pp[5'(i)] = pp[5'(i)] & pp[5'(i - (1 << d))];
      end
    end
    for (int unsigned k = 0; k < 4; k++) begin
      for (int unsigned i = (2 << (3 - k)) + (1 << (3 - k)) - 1; i < 32;
           i += (2 << (3 - k))) begin
        gg[5'(i)] = gg[5'(i)] | (pp[5'(i)] & gg[5'(i - (1 << (3 - k)))]);
        pp[5'(i)] = pp[5'(i)] & pp[5'(i - (1 << (3 - k)))];
      end
    end
  end

  assign sum  = p ^ {gg[30:0], cin};
  assign cout = gg[31];
endmodule

module bk_multiword_add_seq #(
  parameter int unsigned NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bk_multiword_add_seq_if.slave    bus,
  output logic                     busy
);
  localparam int unsigned W  = 32 * NWORDS;
  localparam int unsigned CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  res;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          sub;

  logic [31:0]   core_b;
  logic [31:0]   core_sum;
  logic          core_cout;

`ifdef BK_SUB_EN
  assign core_b = sub ? ~b_reg[31:0] : b_reg[31:0];
`else
  assign core_b = b_reg[31:0];
`endif

  bk_add32 core (
    .a    (a_reg[31:0]),
    .b    (core_b),
    .cin  (carry),
    .sum  (core_sum),
    .cout (core_cout)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = res;
  assign bus.out_cout  = carry;

  // Control FSM with registered handshake outputs and the limb datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
      cnt         <= '0;
      carry       <= 1'b0;
      sub         <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      res         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_reg      <= bus.in_a;
            b_reg      <= bus.in_b;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            busy       <= 1'b1;
            state      <= ADD;
`ifdef BK_SUB_EN
            sub        <= bus.in_sub;
            carry      <= bus.in_sub ? 1'b1 : bus.in_cin;
`else
            sub        <= 1'b0;
            carry      <= bus.in_cin;
`endif
          end
        end
        ADD: begin
          // New limb enters at the top; after NWORDS shifts limb k is at 32k.
          res   <= (res >> 32) | (W'(core_sum) << (W - 32));
          carry <= core_cout;
          a_reg <= a_reg >> 32;
          b_reg <= b_reg >> 32;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(NWORDS - 1)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy        <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bk_multiword_add_seq.sv
// Directed bench for bk_multiword_add_seq with NWORDS=4 (128-bit operands).
module tb_bk_multiword_add_seq;
  logic clk;
  logic rst_n;
  logic busy;
  int   n_cmp;
  int   n_bad;
  int   lat;

  bk_multiword_add_seq_if #(.NWORDS(4)) bus ();

  bk_multiword_add_seq #(.NWORDS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands for one edge; caller guarantees the block is idle.
  task automatic start(input logic [127:0] a, input logic [127:0] b, input logic cin,
                       input logic s);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
`ifdef BK_SUB_EN
    bus.in_sub   = s;
`else
    if (s) $display("note: subtract step skipped in add-only build");
`endif
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid; bounded at 20.
  task automatic wait_valid(output int l);
    l = 0;
    while (!bus.out_valid && l < 20) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
`ifdef BK_SUB_EN
    bus.in_sub    = 1'b0;
`endif
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_sum", bus.out_sum, '0);
    check("rst_out_cout", bus.out_cout, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Carry ripples through every limb.
    start('1, 128'd1, 1'b0, 1'b0);
    check("t1_in_ready_busy", bus.in_ready, 1'b0);
    check("t1_busy", busy, 1'b1);
    wait_valid(lat);
    check("t1_latency", lat, 4);
    check("t1_sum", bus.out_sum, '0);
    check("t1_cout", bus.out_cout, 1'b1);
    drain();
    check("t1_valid_after", bus.out_valid, 1'b0);
    check("t1_ready_after", bus.in_ready, 1'b1);

    // Carry across the limb-0/limb-1 boundary only.
    start(128'hFFFF_FFFF, 128'd1, 1'b0, 1'b0);
    wait_valid(lat);
    check("t2_sum", bus.out_sum, 128'h1_0000_0000);
    check("t2_cout", bus.out_cout, 1'b0);
    drain();

    // Carry-in reaches limb 0.
    start(128'd0, 128'd0, 1'b1, 1'b0);
    wait_valid(lat);
    check("t2c_sum", bus.out_sum, 128'd1);
    drain();

    // Backpressure: result held, new request not taken until handshake.
    start(128'd10, 128'd20, 1'b0, 1'b0);
    wait_valid(lat);
    bus.in_a     = 128'd100;
    bus.in_b     = 128'd200;
    bus.in_cin   = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("t3_hold_sum", bus.out_sum, 128'd30);
      check("t3_hold_valid", bus.out_valid, 1'b1);
      check("t3_hold_in_ready", bus.in_ready, 1'b0);
    end
    check("t3_hold_cout", bus.out_cout, 1'b0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("t3_hs_valid", bus.out_valid, 1'b0);
    check("t3_hs_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("t3_accept_in_ready", bus.in_ready, 1'b0);
    check("t3_accept_busy", busy, 1'b1);
    wait_valid(lat);
    check("t3_latency", lat, 4);
    check("t3_sum", bus.out_sum, 128'd300);
    drain();

    // Asynchronous reset two limbs into ADD.
    start('1, 128'd1, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t4_rst_valid", bus.out_valid, 1'b0);
    check("t4_rst_in_ready", bus.in_ready, 1'b1);
    check("t4_rst_busy", busy, 1'b0);
    check("t4_rst_sum", bus.out_sum, '0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start(128'd3, 128'd4, 1'b0, 1'b0);
    wait_valid(lat);
    check("t4_latency", lat, 4);
    check("t4_sum", bus.out_sum, 128'd7);
    check("t4_cout", bus.out_cout, 1'b0);
    drain();

`ifdef BK_SUB_EN
    // Subtraction: borrow and no-borrow cases; in_cin ignored while subtracting.
    start(128'd5, 128'd7, 1'b0, 1'b1);
    wait_valid(lat);
    check("t5_sum_neg", bus.out_sum, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);
    check("t5_cout_neg", bus.out_cout, 1'b0);
    drain();
    start(128'd7, 128'd5, 1'b1, 1'b1);
    wait_valid(lat);
    check("t5_sum_pos", bus.out_sum, 128'd2);
    check("t5_cout_pos", bus.out_cout, 1'b1);
    drain();
    bus.in_sub = 1'b0;
`endif

    // Back-to-back with in_valid and out_ready both held high.
    bus.out_ready = 1'b1;
    bus.in_a      = 128'd1;
    bus.in_b      = 128'd1;
    bus.in_cin    = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_a = 128'd2;
    bus.in_b = 128'd2;
    wait_valid(lat);
    check("t6_lat1", lat, 4);
    check("t6_sum1", bus.out_sum, 128'd2);
    @(posedge clk);
    #1;
    check("t6_hs_valid", bus.out_valid, 1'b0);
    check("t6_hs_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("t6_accept2", bus.in_ready, 1'b0);
    wait_valid(lat);
    check("t6_lat2", lat, 4);
    check("t6_sum2", bus.out_sum, 128'd4);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("t6_end_valid", bus.out_valid, 1'b0);
    check("t6_end_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
